// File: rtl/life_pkg.sv
// Shared types and default sizes for the Game of Life generation controller.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int unsigned LIFE_WIDTH  = 64;
    localparam int unsigned LIFE_RATE_W = 24;
    localparam int unsigned LIFE_GEN_W  = 16;

    typedef logic [LIFE_WIDTH-1:0] board_t;

endpackage

// File: rtl/life_state_ctrl_rate_divider.sv
// Free-run update-rate divider: ticks once every rate+1 enabled cycles.
module rate_divider #(
    parameter int unsigned RATE_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    logic [RATE_W-1:0] r_cnt;
    logic              w_tick;

    // >= rather than == so a rate lowered below the running count ticks at once
    assign w_tick = en && (r_cnt >= rate);
    assign tick   = w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + RATE_W'(1);
            end
        end
    end

endmodule

// File: rtl/life_state_ctrl.sv
// Generation register and sequencer: holds the current board, commits the next one
// under load/step/run control, counts generations and flags still-life / period-2 boards.
module life_state_ctrl
    import life_pkg::*;
#(
    parameter int unsigned       WIDTH     = LIFE_WIDTH,
    parameter int unsigned       RATE_W    = LIFE_RATE_W,
    parameter int unsigned       GEN_W     = LIFE_GEN_W,
    parameter logic [WIDTH-1:0]  RST_BOARD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic              load,
    input  logic              run,
    input  logic              step,
    input  logic              halt_on_stable,
    input  logic [RATE_W-1:0] rate,
    input  logic [WIDTH-1:0]  game_out,
    output logic [WIDTH-1:0]  game_in,
    output logic [GEN_W-1:0]  gen_count,
    output logic              update,
    output logic              stable,
    output logic              osc2,
    output logic              halted
);

    state_e             r_state;
    state_e             w_next_state;
    logic [WIDTH-1:0]   r_board;
    logic [WIDTH-1:0]   r_hist1;
    logic [GEN_W-1:0]   r_gen;
    logic               r_update;
    logic               r_stable;
    logic               r_osc2;

    logic               w_tick;
    logic               w_div_en;
    logic               w_div_clr;
    logic               w_halt_cond;
    logic               w_commit;

    assign w_div_en  = (r_state == RUN);
    assign w_div_clr = load || ((r_state == IDLE) && run);

    rate_divider #(
        .RATE_W (RATE_W)
    ) u_rate_divider (
        .clk   (clk),
        .reset (reset),
        .en    (w_div_en),
        .clr   (w_div_clr),
        .rate  (rate),
        .tick  (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        w_halt_cond  = (r_state == RUN) && halt_on_stable && (r_stable || r_osc2);
        w_commit     = 1'b0;

        case (r_state)
            IDLE: begin
                if (run) w_next_state = RUN;
                w_commit = step;
            end
            RUN: begin
                if (w_halt_cond)   w_next_state = HALT;
                else if (!run)     w_next_state = IDLE;
                // The flagged board is final: no commit in the cycle that enters HALT
                w_commit = w_tick && !w_halt_cond;
            end
            HALT: begin
                w_next_state = HALT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (load) begin
            w_next_state = IDLE;
            w_commit     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_board  <= RST_BOARD;
            r_hist1  <= RST_BOARD;
            r_gen    <= '0;
            r_update <= 1'b0;
            r_stable <= 1'b0;
            r_osc2   <= 1'b0;
        end else if (load) begin
            r_board  <= seed_in;
            r_hist1  <= seed_in;
            r_gen    <= '0;
            r_update <= 1'b0;
            r_stable <= 1'b0;
            r_osc2   <= 1'b0;
        end else if (w_commit) begin
            r_board  <= game_out;
            r_hist1  <= r_board;
            if (r_gen != '1) r_gen <= r_gen + GEN_W'(1);
            r_update <= 1'b1;
            r_stable <= (game_out == r_board);
            r_osc2   <= (game_out == r_hist1) && (game_out != r_board);
        end else begin
            r_update <= 1'b0;
        end
    end

    assign game_in   = r_board;
    assign gen_count = r_gen;
    assign update    = r_update;
    assign stable    = r_stable;
    assign osc2      = r_osc2;
    assign halted    = (r_state == HALT);

endmodule

// File: tb/tb_life_state_ctrl.sv
// Directed bench for life_state_ctrl (WIDTH=16, GEN_W=4) with a selectable next-state model.
module tb_life_state_ctrl;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned RATE_W = 8;
    localparam int unsigned GEN_W  = 4;

    logic              clk;
    logic              reset;
    logic [WIDTH-1:0]  seed_in;
    logic              load;
    logic              run;
    logic              step;
    logic              halt_on_stable;
    logic [RATE_W-1:0] rate;
    logic [WIDTH-1:0]  game_out;
    logic [WIDTH-1:0]  game_in;
    logic [GEN_W-1:0]  gen_count;
    logic              update;
    logic              stable;
    logic              osc2;
    logic              halted;

    // 0 = rotate-left-1, 1 = identity, 2 = complement
    int unsigned mode;
    int unsigned n_checks;
    int unsigned n_errors;

    assign game_out = (mode == 1) ? game_in :
                      (mode == 2) ? ~game_in :
                      {game_in[WIDTH-2:0], game_in[WIDTH-1]};

    life_state_ctrl #(
        .WIDTH     (WIDTH),
        .RATE_W    (RATE_W),
        .GEN_W     (GEN_W),
        .RST_BOARD (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .seed_in        (seed_in),
        .load           (load),
        .run            (run),
        .step           (step),
        .halt_on_stable (halt_on_stable),
        .rate           (rate),
        .game_out       (game_out),
        .game_in        (game_in),
        .gen_count      (gen_count),
        .update         (update),
        .stable         (stable),
        .osc2           (osc2),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; mode = 0;
        reset = 1'b1; seed_in = '0; load = 0; run = 0; step = 0;
        halt_on_stable = 0; rate = '0;
        #1;
        chk("rst_board", 64'(game_in), 64'h0);
        chk("rst_gen",   64'(gen_count), 64'h0);
        chk("rst_flags", 64'({update, stable, osc2, halted}), 64'h0);
        cyc(2);
        reset = 1'b0;

        // free-run at rate=3: commit every 4th clock
        seed_in = 16'h0001; load = 1;
        cyc(1);
        load = 0; run = 1; rate = 8'd3;
        chk("load_board", 64'(game_in), 64'h0001);
        chk("load_gen",   64'(gen_count), 64'h0);
        cyc(4);
        chk("run_wait_board",  64'(game_in), 64'h0001);
        chk("run_wait_update", 64'(update), 64'h0);
        cyc(1);
        chk("run_c1_board",  64'(game_in), 64'h0002);
        chk("run_c1_gen",    64'(gen_count), 64'h1);
        chk("run_c1_update", 64'(update), 64'h1);
        cyc(1);
        chk("run_upd_pulse", 64'(update), 64'h0);
        cyc(3);
        chk("run_c2_board", 64'(game_in), 64'h0004);
        chk("run_c2_gen",   64'(gen_count), 64'h2);
        cyc(4);
        chk("run_c3_board", 64'(game_in), 64'h0008);
        chk("run_c3_gen",   64'(gen_count), 64'h3);
        chk("run_c3_flags", 64'({stable, osc2}), 64'h0);
        run = 0;
        cyc(1);

        // single-step while paused
        seed_in = 16'h0001; load = 1;
        cyc(1);
        load = 0; step = 1;
        cyc(1);
        step = 0;
        chk("step1_board",  64'(game_in), 64'h0002);
        chk("step1_gen",    64'(gen_count), 64'h1);
        chk("step1_update", 64'(update), 64'h1);
        cyc(1);
        chk("step_gap_board", 64'(game_in), 64'h0002);
        step = 1;
        cyc(1);
        step = 0;
        chk("step2_board", 64'(game_in), 64'h0004);
        chk("step2_gen",   64'(gen_count), 64'h2);
        run = 1; rate = 8'd9;
        cyc(1);
        step = 1;
        cyc(1);
        step = 0;
        chk("step_in_run_board", 64'(game_in), 64'h0004);
        chk("step_in_run_gen",   64'(gen_count), 64'h2);
        run = 0;
        cyc(1);

        // still life with auto-halt
        mode = 1; halt_on_stable = 1; rate = 8'd0;
        seed_in = 16'h1234; load = 1;
        cyc(1);
        load = 0; run = 1;
        cyc(1);
        chk("halt_pre", 64'(halted), 64'h0);
        cyc(1);
        chk("stab_board",  64'(game_in), 64'h1234);
        chk("stab_flag",   64'({stable, osc2}), 64'h2);
        chk("stab_gen",    64'(gen_count), 64'h1);
        chk("stab_nohalt", 64'(halted), 64'h0);
        cyc(1);
        chk("halt_set", 64'(halted), 64'h1);
        chk("halt_gen", 64'(gen_count), 64'h1);
        step = 1;
        cyc(2);
        step = 0;
        chk("halt_hold",     64'(halted), 64'h1);
        chk("halt_gen_hold", 64'(gen_count), 64'h1);
        chk("halt_upd",      64'(update), 64'h0);

        // period-2 oscillator, no halt
        mode = 2; halt_on_stable = 0;
        seed_in = 16'h00FF; load = 1;
        cyc(1);
        load = 0;
        chk("osc_load_board", 64'(game_in), 64'h00FF);
        chk("osc_load_flags", 64'({stable, osc2, halted}), 64'h0);
        cyc(2);
        chk("osc_g1_board", 64'(game_in), 64'hFF00);
        chk("osc_g1_gen",   64'(gen_count), 64'h1);
        chk("osc_g1_osc2",  64'(osc2), 64'h0);
        cyc(1);
        chk("osc_g2_board", 64'(game_in), 64'h00FF);
        chk("osc_g2_flags", 64'({stable, osc2}), 64'h1);
        cyc(1);
        chk("osc_g3_flags", 64'({stable, osc2, halted}), 64'h2);
        chk("osc_g3_gen",   64'(gen_count), 64'h3);

        // generation counter saturation, then load beating step
        cyc(20);
        chk("gen_sat", 64'(gen_count), 64'hF);
        run = 0; step = 1; load = 1; seed_in = 16'hABCD;
        cyc(1);
        load = 0; step = 0;
        chk("ld_step_board", 64'(game_in), 64'hABCD);
        chk("ld_step_gen",   64'(gen_count), 64'h0);
        chk("ld_step_upd",   64'(update), 64'h0);
        cyc(1);
        chk("ld_step_after", 64'(gen_count), 64'h0);

        // rate lowered below the running count
        mode = 0; seed_in = 16'h0001; load = 1;
        cyc(1);
        load = 0; run = 1; rate = 8'd9;
        cyc(6);
        chk("rchg_pre", 64'(game_in), 64'h0001);
        rate = 8'd2;
        cyc(1);
        chk("rchg_tick", 64'(game_in), 64'h0002);
        cyc(2);
        chk("rchg_wait", 64'(game_in), 64'h0002);
        cyc(1);
        chk("rchg_next", 64'(game_in), 64'h0004);

        // asynchronous reset in the middle of a run
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_board", 64'(game_in), 64'h0);
        chk("mid_rst_gen",   64'(gen_count), 64'h0);
        chk("mid_rst_flags", 64'({update, stable, osc2, halted}), 64'h0);
        cyc(1);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
